// File: rtl/cp0_regs_if.sv
// Write-back CP0 write request and mfc0 read port shared by the pipeline and cp0_regs.
interface cp0_regs_if;
    typedef struct packed {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } RegWriteReq_t;

    RegWriteReq_t wb_cp0_reg_wr;
    logic [4:0]   rd_addr;
    logic [31:0]  rd_data;

    modport master (output wb_cp0_reg_wr, output rd_addr, input rd_data);
    modport slave  (input wb_cp0_reg_wr, input rd_addr, output rd_data);
endinterface

// File: rtl/cp0_regs.sv
// CP0 register file: mtc0 commit, mfc0 read with write bypass, Count/Compare timer,
// exception/eret state tracking and interrupt-pending generation.
module cp0_regs (
    input  logic        clk,
    input  logic        rst,
    cp0_regs_if.slave   bus,
    input  logic [5:0]  int_i,
    input  logic        exc_valid,
    input  logic [4:0]  exc_code,
    input  logic [31:0] exc_pc,
    input  logic        exc_bd,
    input  logic        exc_badvaddr_we,
    input  logic [31:0] exc_badvaddr,
    input  logic        eret,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic        int_pending
);
    localparam logic [4:0]  REG_BADVADDR = 5'd8;
    localparam logic [4:0]  REG_COUNT    = 5'd9;
    localparam logic [4:0]  REG_COMPARE  = 5'd11;
    localparam logic [4:0]  REG_STATUS   = 5'd12;
    localparam logic [4:0]  REG_CAUSE    = 5'd13;
    localparam logic [4:0]  REG_EPC      = 5'd14;
    localparam logic [4:0]  REG_PRID     = 5'd15;
    localparam logic [31:0] STATUS_RESET = 32'h0040_0000;
    localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
    localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;
    localparam logic [31:0] PRID_VALUE   = 32'h0001_8000;

    logic [31:0] badvaddr, count, compare, status, cause, epc;
    logic        count_tog;
    logic [31:0] badvaddr_next, count_next, compare_next, status_next, cause_next, epc_next;
    logic        count_tog_next, ti_next, exl_next;
    logic        wr_count, wr_compare, wr_status, wr_cause, wr_epc;
    logic [31:0] wdata, status_wr, cause_wr, rd_value;

    assign wdata      = bus.wb_cp0_reg_wr.wdata;
    assign wr_count   = bus.wb_cp0_reg_wr.we && (bus.wb_cp0_reg_wr.waddr == REG_COUNT);
    assign wr_compare = bus.wb_cp0_reg_wr.we && (bus.wb_cp0_reg_wr.waddr == REG_COMPARE);
    assign wr_status  = bus.wb_cp0_reg_wr.we && (bus.wb_cp0_reg_wr.waddr == REG_STATUS);
    assign wr_cause   = bus.wb_cp0_reg_wr.we && (bus.wb_cp0_reg_wr.waddr == REG_CAUSE);
    assign wr_epc     = bus.wb_cp0_reg_wr.we && (bus.wb_cp0_reg_wr.waddr == REG_EPC);

    // Software view of a write: only the writable fields take the new data, BEV stays set.
    assign status_wr = (status & ~STATUS_WMASK) | (wdata & STATUS_WMASK);
    assign cause_wr  = (cause & ~CAUSE_WMASK) | (wdata & CAUSE_WMASK);

    // Next-state: exception beats eret beats software write, field by field.
    always_comb begin
        if (wr_compare) begin
            ti_next = 1'b0;
        end else if ((count == compare) && (compare != 32'd0)) begin
            ti_next = 1'b1;
        end else begin
            ti_next = cause[30];
        end

        if (exc_valid) begin
            exl_next = 1'b1;
        end else if (eret) begin
            exl_next = 1'b0;
        end else if (wr_status) begin
            exl_next = wdata[1];
        end else begin
            exl_next = status[1];
        end
        status_next    = wr_status ? status_wr : status;
        status_next[1] = exl_next;

        // IP7 shares its line with the timer; it follows the TI value being latched now.
        cause_next        = wr_cause ? cause_wr : cause;
        cause_next[30]    = ti_next;
        cause_next[15:10] = {int_i[5] | ti_next, int_i[4:0]};
        if (exc_valid) begin
            cause_next[6:2] = exc_code;
            cause_next[31]  = status[1] ? cause[31] : exc_bd;
        end else begin
            cause_next[6:2] = cause[6:2];
            cause_next[31]  = cause[31];
        end

        if (exc_valid) begin
            epc_next = status[1] ? epc : (exc_bd ? (exc_pc - 32'd4) : exc_pc);
        end else if (wr_epc) begin
            epc_next = wdata;
        end else begin
            epc_next = epc;
        end

        if (exc_valid && exc_badvaddr_we) begin
            badvaddr_next = exc_badvaddr;
        end else begin
            badvaddr_next = badvaddr;
        end

        compare_next = wr_compare ? wdata : compare;

        if (wr_count) begin
            count_next     = wdata;
            count_tog_next = 1'b0;
        end else begin
            count_next     = count + {31'd0, count_tog};
            count_tog_next = ~count_tog;
        end
    end

    // State registers with synchronous reset overriding every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            badvaddr  <= 32'd0;
            count     <= 32'd0;
            count_tog <= 1'b0;
            compare   <= 32'd0;
            status    <= STATUS_RESET;
            cause     <= 32'd0;
            epc       <= 32'd0;
        end else begin
            badvaddr  <= badvaddr_next;
            count     <= count_next;
            count_tog <= count_tog_next;
            compare   <= compare_next;
            status    <= status_next;
            cause     <= cause_next;
            epc       <= epc_next;
        end
    end

    // mfc0 read; a same-cycle write to the addressed register is forwarded.
    always_comb begin
        case (bus.rd_addr)
            REG_BADVADDR: rd_value = badvaddr;
            REG_COUNT:    rd_value = wr_count ? wdata : count;
            REG_COMPARE:  rd_value = wr_compare ? wdata : compare;
            REG_STATUS:   rd_value = wr_status ? status_wr : status;
            REG_CAUSE:    rd_value = wr_cause ? cause_wr : cause;
            REG_EPC:      rd_value = wr_epc ? wdata : epc;
            REG_PRID:     rd_value = PRID_VALUE;
            default:      rd_value = 32'd0;
        endcase
    end

    assign bus.rd_data  = rd_value;
    assign status_o     = status;
    assign cause_o      = cause;
    assign epc_o        = epc;
    assign int_pending  = status[0] & ~status[1] & (|(cause[15:8] & status[15:8]));
endmodule
